systolic_array: RTL and testbench

//  Weight-stationary NxN MAC array for the tensor core: computes O[r] = I[r] x W + P[r] one row at a time.
//  The memory side loads weights, input rows and partial-sum rows through systolic_array_if (modport memory_array).

---
 rtl/systolic_array_if.sv | 49 ++++
 rtl/systolic_array.sv | 273 +++++++++++++++++++++++++++
 tb/tb_systolic_array.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_array_if.sv
// rtl/systolic_array_if.sv - memory-side bus bundle for the weight-stationary systolic MAC array
//
// Signals (directions as seen by the array through modport memory_array):
//   weight_en          in   write array_in as weight row row_in_en
//   input_en           in   push array_in as input row row_in_en
//   partial_en         in   push array_in_partials as partial row row_ps_en
//   row_in_en          in   row index for weight/input writes
//   row_ps_en          in   row index for partial writes
//   array_in           in   N lanes of WIDTH bits, lane k at [(k+1)*WIDTH-1 -: WIDTH]
//   array_in_partials  in   same lane packing
//   out_en             out  one-cycle pulse per finished row
//   row_out            out  row index of the finished row
//   array_output       out  finished row, same lane packing
//   drained            out  nothing buffered or in flight
//   fifo_has_space     out  every input and partial buffer has a free slot
interface systolic_array_if #(
    parameter int N     = 4,
    parameter int WIDTH = 16
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic                 weight_en;
    logic                 input_en;
    logic                 partial_en;
    logic [RW-1:0]        row_in_en;
    logic [RW-1:0]        row_ps_en;
    logic [N*WIDTH-1:0]   array_in;
    logic [N*WIDTH-1:0]   array_in_partials;
    logic                 out_en;
    logic [RW-1:0]        row_out;
    logic [N*WIDTH-1:0]   array_output;
    logic                 drained;
    logic                 fifo_has_space;

    modport memory_array (
        input  weight_en,
        input  input_en,
        input  partial_en,
        input  row_in_en,
        input  row_ps_en,
        input  array_in,
        input  array_in_partials,
        output out_en,
        output row_out,
        output array_output,
        output drained,
        output fifo_has_space
    );
endinterface

// File: rtl/systolic_array.sv
// rtl/systolic_array.sv - weight-stationary NxN MAC array computing O[r] = I[r] x W + P[r] per row
//
// Ports:
//   clk   in   single clock, rising edge
//   nRST  in   asynchronous active-high reset
//   bus   systolic_array_if.memory_array: weight/input/partial loads in, tagged result rows out
//
// Datapath: per-row input and partial FIFOs (depth 2) feed an issue stage that picks
// the lowest-index row with both heads present. Issued lanes are skewed into an NxN
// grid of PEs; PE[j][k] holds W[j][k], inputs move right along row j and partial sums
// move down column k. Column outputs are deskewed so a whole row appears together,
// giving a fixed 2N-edge latency from issue to out_en.
module systolic_array #(
    parameter int N     = 4,
    parameter int WIDTH = 16
) (
    input logic                    clk,
    input logic                    nRST,
    systolic_array_if.memory_array bus
);
    localparam int RW  = (N > 1) ? $clog2(N) : 1;
    localparam int BW  = N * WIDTH;
    localparam int LAT = 2 * N;

    // Weights and row buffers
    logic [WIDTH-1:0] w      [N][N];
    logic [BW-1:0]    in_mem [N][2];
    logic [BW-1:0]    ps_mem [N][2];
    logic [1:0]       in_cnt [N];
    logic [1:0]       ps_cnt [N];
    logic             in_wp  [N];
    logic             in_rp  [N];
    logic             ps_wp  [N];
    logic             ps_rp  [N];

    logic [N-1:0]     in_push;
    logic [N-1:0]     ps_push;
    logic [N-1:0]     pop;
    logic [N-1:0]     ready;
    logic             issue;
    logic [RW-1:0]    issue_row;
    logic [BW-1:0]    head_in;
    logic [BW-1:0]    head_ps;
    logic             any_full;
    logic             fifos_empty;
    logic             drained_c;

    // Pipeline bookkeeping and result register
    logic [LAT-1:0]   vld;
    logic [RW-1:0]    tag [LAT];
    logic             out_en_q;
    logic [RW-1:0]    row_out_q;
    logic [BW-1:0]    out_q;

    // Systolic grid wiring
    logic [WIDTH-1:0] x_edge [N];
    logic [WIDTH-1:0] p_edge [N];
    logic [WIDTH-1:0] x_pe   [N][N];
    logic [WIDTH-1:0] s_pe   [N][N];
    logic [WIDTH-1:0] col_al [N];
    logic [BW-1:0]    col_flat;

    // Push qualification, readiness and buffer status
    always_comb begin
        in_push     = '0;
        ps_push     = '0;
        ready       = '0;
        any_full    = 1'b0;
        fifos_empty = 1'b1;
        for (int r = 0; r < N; r++) begin
            // A weight write in the same cycle takes the shared row_in_en/array_in bus.
            in_push[r] = bus.input_en && !bus.weight_en &&
                         (bus.row_in_en == RW'(r)) && (in_cnt[r] != 2'd2);
            ps_push[r] = bus.partial_en && (bus.row_ps_en == RW'(r)) && (ps_cnt[r] != 2'd2);
            ready[r]   = (in_cnt[r] != 2'd0) && (ps_cnt[r] != 2'd0);
            if (in_cnt[r] == 2'd2 || ps_cnt[r] == 2'd2) begin
                any_full = 1'b1;
            end
            if (in_cnt[r] != 2'd0 || ps_cnt[r] != 2'd0) begin
                fifos_empty = 1'b0;
            end
        end
    end

    // Lowest-index ready row wins; readiness comes from registered counts, so a pair
    // completed at one edge is first seen at the next.
    always_comb begin
        issue     = |ready;
        issue_row = '0;
        pop       = '0;
        for (int r = N - 1; r >= 0; r--) begin
            if (ready[r]) begin
                issue_row = RW'(r);
            end
        end
        if (issue) begin
            pop[issue_row] = 1'b1;
        end
        head_in = in_mem[issue_row][in_rp[issue_row]];
        head_ps = ps_mem[issue_row][ps_rp[issue_row]];
    end

    assign drained_c = fifos_empty && !(|vld) && !out_en_q;

    // Weight store and row FIFOs
    always_ff @(posedge clk or posedge nRST) begin
        if (nRST) begin
            for (int r = 0; r < N; r++) begin
                for (int k = 0; k < N; k++) begin
                    w[r][k] <= '0;
                end
                in_mem[r][0] <= '0;
                in_mem[r][1] <= '0;
                ps_mem[r][0] <= '0;
                ps_mem[r][1] <= '0;
                in_cnt[r]    <= '0;
                ps_cnt[r]    <= '0;
                in_wp[r]     <= 1'b0;
                in_rp[r]     <= 1'b0;
                ps_wp[r]     <= 1'b0;
                ps_rp[r]     <= 1'b0;
            end
        end else begin
            // Weights change only when nothing can be mid-computation.
            if (bus.weight_en && drained_c) begin
                for (int k = 0; k < N; k++) begin
                    w[bus.row_in_en][k] <= bus.array_in[k*WIDTH +: WIDTH];
                end
            end
            for (int r = 0; r < N; r++) begin
                if (in_push[r]) begin
                    in_mem[r][in_wp[r]] <= bus.array_in;
                    in_wp[r]            <= ~in_wp[r];
                end
                if (ps_push[r]) begin
                    ps_mem[r][ps_wp[r]] <= bus.array_in_partials;
                    ps_wp[r]            <= ~ps_wp[r];
                end
                if (pop[r]) begin
                    in_rp[r] <= ~in_rp[r];
                    ps_rp[r] <= ~ps_rp[r];
                end
                case ({in_push[r], pop[r]})
                    2'b10:   in_cnt[r] <= in_cnt[r] + 2'd1;
                    2'b01:   in_cnt[r] <= in_cnt[r] - 2'd1;
                    default: in_cnt[r] <= in_cnt[r];
                endcase
                case ({ps_push[r], pop[r]})
                    2'b10:   ps_cnt[r] <= ps_cnt[r] + 2'd1;
                    2'b01:   ps_cnt[r] <= ps_cnt[r] - 2'd1;
                    default: ps_cnt[r] <= ps_cnt[r];
                endcase
            end
        end
    end

    // Input skew: lane j reaches PE[j][0] j edges after issue. Partial skew: column k's
    // seed reaches PE[0][k] k edges after issue. Both chains have length j+1 / k+1.
    for (genvar j = 0; j < N; j++) begin : g_skew
        logic [WIDTH-1:0] xs  [j+1];
        logic [WIDTH-1:0] psk [j+1];

        always_ff @(posedge clk or posedge nRST) begin
            if (nRST) begin
                for (int d = 0; d <= j; d++) begin
                    xs[d]  <= '0;
                    psk[d] <= '0;
                end
            end else begin
                xs[0]  <= issue ? head_in[j*WIDTH +: WIDTH] : '0;
                psk[0] <= issue ? head_ps[j*WIDTH +: WIDTH] : '0;
                for (int d = 1; d <= j; d++) begin
                    xs[d]  <= xs[d-1];
                    psk[d] <= psk[d-1];
                end
            end
        end

        assign x_edge[j] = xs[j];
        assign p_edge[j] = psk[j];
    end

    // PE grid: PE[j][k] fires j+k+1 edges after issue for a given row.
    for (genvar j = 0; j < N; j++) begin : g_row
        for (genvar k = 0; k < N; k++) begin : g_col
            logic [WIDTH-1:0] x_d;
            logic [WIDTH-1:0] s_d;
            logic [WIDTH-1:0] x_q;
            logic [WIDTH-1:0] s_q;

            if (k == 0) begin : g_xl
                assign x_d = x_edge[j];
            end else begin : g_xr
                assign x_d = x_pe[j][k-1];
            end
            if (j == 0) begin : g_st
                assign s_d = p_edge[k];
            end else begin : g_sb
                assign s_d = s_pe[j-1][k];
            end

            always_ff @(posedge clk or posedge nRST) begin
                if (nRST) begin
                    x_q <= '0;
                    s_q <= '0;
                end else begin
                    x_q <= x_d;
                    s_q <= s_d + x_d * w[j][k];
                end
            end

            assign x_pe[j][k] = x_q;
            assign s_pe[j][k] = s_q;
        end
    end

    // Deskew: column k leaves the grid N+k edges after issue; delay it so every column
    // is aligned 2N-1 edges after issue.
    for (genvar k = 0; k < N; k++) begin : g_deskew
        localparam int L = N - 1 - k;
        if (L == 0) begin : g_direct
            assign col_al[k] = s_pe[N-1][k];
        end else begin : g_delay
            logic [WIDTH-1:0] dq [L];
            always_ff @(posedge clk or posedge nRST) begin
                if (nRST) begin
                    for (int d = 0; d < L; d++) begin
                        dq[d] <= '0;
                    end
                end else begin
                    dq[0] <= s_pe[N-1][k];
                    for (int d = 1; d < L; d++) begin
                        dq[d] <= dq[d-1];
                    end
                end
            end
            assign col_al[k] = dq[L-1];
        end
        assign col_flat[k*WIDTH +: WIDTH] = col_al[k];
    end

    // Valid/tag chain tracks each issued row alongside the grid; the output register
    // is the 2N-th stage.
    always_ff @(posedge clk or posedge nRST) begin
        if (nRST) begin
            vld       <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag[i] <= '0;
            end
            out_en_q  <= 1'b0;
            row_out_q <= '0;
            out_q     <= '0;
        end else begin
            vld    <= {vld[LAT-2:0], issue};
            tag[0] <= issue_row;
            for (int i = 1; i < LAT; i++) begin
                tag[i] <= tag[i-1];
            end
            out_en_q <= vld[LAT-1];
            if (vld[LAT-1]) begin
                row_out_q <= tag[LAT-1];
                out_q     <= col_flat;
            end
        end
    end

    assign bus.out_en         = out_en_q;
    assign bus.row_out        = row_out_q;
    assign bus.array_output   = out_q;
    assign bus.drained        = drained_c;
    assign bus.fifo_has_space = !any_full;

endmodule

// File: tb/tb_systolic_array.sv
// tb/tb_systolic_array.sv - scoreboard bench for systolic_array (N=4, WIDTH=16)
module tb_systolic_array;
    localparam int N     = 4;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic nRST;
    always #5 clk = ~clk;

    systolic_array_if #(.N(N), .WIDTH(WIDTH)) bus ();
    systolic_array #(.N(N), .WIDTH(WIDTH)) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    typedef struct {
        logic [1:0]  row;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] mw [4][4];
    logic [63:0] m_in [4][2];
    logic [63:0] m_ps [4][2];
    int          m_in_n [4];
    int          m_ps_n [4];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          out_cyc  = 0;
    int          n_out    = 0;
    int          push_cyc;
    int          nb;
    logic [63:0] v;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lanes(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [63:0] compute(input logic [63:0] i, input logic [63:0] p);
        logic [63:0] res;
        logic [15:0] acc;
        res = '0;
        for (int k = 0; k < 4; k++) begin
            acc = p[k*16 +: 16];
            for (int j = 0; j < 4; j++) begin
                acc = acc + i[j*16 +: 16] * mw[j][k];
            end
            res[k*16 +: 16] = acc;
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        sb.delete();
        for (int r = 0; r < 4; r++) begin
            m_in_n[r] = 0;
            m_ps_n[r] = 0;
            for (int k = 0; k < 4; k++) mw[r][k] = '0;
        end
    endtask

    // Pair heads in completion order; stimulus keeps this equal to issue order.
    task automatic model_resolve();
        for (int r = 0; r < 4; r++) begin
            while (m_in_n[r] > 0 && m_ps_n[r] > 0) begin
                sb.push_back('{row: 2'(r), data: compute(m_in[r][0], m_ps[r][0])});
                m_in[r][0] = m_in[r][1];
                m_ps[r][0] = m_ps[r][1];
                m_in_n[r]--;
                m_ps_n[r]--;
            end
        end
    endtask

    task automatic drive(input logic ie, input logic pe, input logic [1:0] ri,
                         input logic [1:0] rp, input logic [63:0] ai, input logic [63:0] ap);
        bus.input_en          = ie;
        bus.partial_en        = pe;
        bus.row_in_en         = ri;
        bus.row_ps_en         = rp;
        bus.array_in          = ai;
        bus.array_in_partials = ap;
        if (ie && m_in_n[ri] < 2) begin
            m_in[ri][m_in_n[ri]] = ai;
            m_in_n[ri]++;
        end
        if (pe && m_ps_n[rp] < 2) begin
            m_ps[rp][m_ps_n[rp]] = ap;
            m_ps_n[rp]++;
        end
        tick();
        bus.input_en   = 1'b0;
        bus.partial_en = 1'b0;
        model_resolve();
    endtask

    task automatic write_weight(input logic [1:0] r, input logic [63:0] val, input bit accept);
        bus.weight_en = 1'b1;
        bus.row_in_en = r;
        bus.array_in  = val;
        if (accept) begin
            for (int k = 0; k < 4; k++) mw[r][k] = val[k*16 +: 16];
        end
        tick();
        bus.weight_en = 1'b0;
    endtask

    task automatic load_identity();
        for (int r = 0; r < 4; r++) write_weight(2'(r), 64'd1 << (16 * r), 1'b1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && bus.drained === 1'b1) break;
            tick();
        end
        check(tag, 64'(sb.size() == 0 && bus.drained === 1'b1), 64'd1);
    endtask

    always @(negedge clk) begin
        if (bus.out_en === 1'b1) begin
            out_cyc = cyc;
            n_out++;
            if (sb.size() == 0) begin
                check("spurious_out_en", 64'(bus.out_en), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("row_out", 64'(bus.row_out), 64'(mon_e.row));
                check("array_output", bus.array_output, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.weight_en = 0; bus.input_en = 0; bus.partial_en = 0;
        bus.row_in_en = 0; bus.row_ps_en = 0;
        bus.array_in = '0; bus.array_in_partials = '0;
        model_clear();
        nRST = 1'b1;
        tick();
        check("rst_out_en", 64'(bus.out_en), 64'd0);
        check("rst_row_out", 64'(bus.row_out), 64'd0);
        check("rst_array_output", bus.array_output, 64'd0);
        check("rst_drained", 64'(bus.drained), 64'd1);
        check("rst_fifo_has_space", 64'(bus.fifo_has_space), 64'd1);
        nRST = 1'b0;
        tick();

        // 1) identity weights, one row per two cycles
        load_identity();
        nb = n_out;
        for (int r = 0; r < 4; r++) begin
            drive(1, 1, 2'(r), 2'(r), lanes(r + 1, 2 * (r + 1), 3 * (r + 1), 4 * (r + 1)), '0);
            if (r == 0) check("t1_drained_low", 64'(bus.drained), 64'd0);
            tick();
        end
        wait_done("t1_done");
        check("t1_count", 64'(n_out - nb), 64'd4);

        // 2) all-2 weights, exact latency from pair completion
        for (int r = 0; r < 4; r++) write_weight(2'(r), lanes(2, 2, 2, 2), 1'b1);
        drive(1, 0, 2'd0, 2'd0, lanes(1, 1, 1, 1), '0);
        drive(0, 1, 2'd0, 2'd0, '0, lanes(5, 6, 7, 8));
        push_cyc = cyc;
        wait_done("t2_done");
        check("t2_latency", 64'(out_cyc - push_cyc), 64'd9);

        // 3) inputs first, partials later
        load_identity();
        nb = n_out;
        for (int r = 0; r < 4; r++)
            drive(1, 0, 2'(r), 2'(r), lanes(3 * (4 * r + 1), 3 * (4 * r + 2), 3 * (4 * r + 3), 3 * (4 * r + 4)), '0);
        repeat (3) tick();
        check("t3_no_issue", 64'(n_out - nb), 64'd0);
        check("t3_drained_low", 64'(bus.drained), 64'd0);
        check("t3_space", 64'(bus.fifo_has_space), 64'd1);
        for (int r = 0; r < 4; r++)
            drive(0, 1, 2'(r), 2'(r), '0, lanes(100 * r, 100 * r + 1, 100 * r + 2, 100 * r + 3));
        wait_done("t3_done");
        check("t3_count", 64'(n_out - nb), 64'd4);

        // 4) overfill row 1 input FIFO
        nb = n_out;
        drive(1, 0, 2'd1, 2'd0, lanes(1, 0, 0, 0), '0);
        check("t4_space_one", 64'(bus.fifo_has_space), 64'd1);
        drive(1, 0, 2'd1, 2'd0, lanes(0, 2, 0, 0), '0);
        check("t4_space_full", 64'(bus.fifo_has_space), 64'd0);
        drive(1, 0, 2'd1, 2'd0, lanes(0, 0, 9, 9), '0);
        check("t4_space_drop", 64'(bus.fifo_has_space), 64'd0);
        drive(0, 1, 2'd0, 2'd1, '0, lanes(10, 10, 10, 10));
        check("t4_space_before_issue", 64'(bus.fifo_has_space), 64'd0);
        tick();
        check("t4_space_after_issue", 64'(bus.fifo_has_space), 64'd1);
        drive(0, 1, 2'd0, 2'd1, '0, lanes(20, 20, 20, 20));
        wait_done("t4_done");
        check("t4_count", 64'(n_out - nb), 64'd2);

        // 5) wraparound, then a weight write while busy must be ignored
        drive(1, 1, 2'd2, 2'd2, lanes(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), lanes(1, 1, 1, 1));
        check("t5_busy", 64'(bus.drained), 64'd0);
        write_weight(2'd2, lanes(16'h1234, 16'h1234, 16'h1234, 16'h1234), 1'b0);
        wait_done("t5_wrap_done");
        drive(1, 1, 2'd2, 2'd2, lanes(7, 8, 9, 10), '0);
        wait_done("t5_weight_kept");

        // 6) reset with rows in flight
        drive(1, 1, 2'd0, 2'd0, lanes(1, 2, 3, 4), lanes(1, 1, 1, 1));
        drive(1, 1, 2'd1, 2'd1, lanes(5, 6, 7, 8), lanes(2, 2, 2, 2));
        drive(1, 1, 2'd2, 2'd2, lanes(9, 9, 9, 9), lanes(3, 3, 3, 3));
        repeat (2) tick();
        nRST = 1'b1;
        model_clear();
        nb = n_out;
        tick();
        nRST = 1'b0;
        repeat (20) tick();
        check("t6_no_out", 64'(n_out - nb), 64'd0);
        check("t6_drained", 64'(bus.drained), 64'd1);
        check("t6_space", 64'(bus.fifo_has_space), 64'd1);
        check("t6_array_output", bus.array_output, 64'd0);
        check("t6_row_out", 64'(bus.row_out), 64'd0);
        drive(1, 1, 2'd3, 2'd3, lanes(4, 5, 6, 7), lanes(11, 12, 13, 14));
        wait_done("t6_zero_weights");
        load_identity();
        drive(1, 1, 2'd0, 2'd0, lanes(21, 22, 23, 24), lanes(1, 2, 3, 4));
        drive(1, 1, 2'd3, 2'd3, lanes(31, 32, 33, 34), lanes(5, 6, 7, 8));
        wait_done("t6_batch_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
